mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's memory read/write strobes.
- Accepts one read or write request at a time, inserts a programmable number of wait states, then completes it:
  - read: returns data with a one-cycle valid pulse;
  - write: commits the data.
- Sits between the controller/datapath address mux (PC or TR source) and the unified instruction/data store. Gives the controller a ready/done handshake in place of fixed single-cycle memory.

---
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait
// states. Accepts one read or write, waits WAIT_CYCLES, performs the access,
// then spends one DONE cycle pulsing data_valid or write_done.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 13,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              data_valid,
  output logic              write_done,
  output logic              req_err,
  output logic              overrun
);
  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              op_wr_q, op_wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;

  // Access performed this edge; with zero wait states it uses the live request.
  logic              do_op;
  logic              op_wr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;

  // Next-state: accept in IDLE/DONE, count down in WAIT, complete at count 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    op_wr_d   = op_wr_q;
    err_d     = 1'b0;
    overrun_d = overrun_q;
    do_op     = 1'b0;
    op_wr     = op_wr_q;
    op_addr   = addr_q;
    op_wdata  = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (mem_read && mem_write) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (mem_read || mem_write) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_wr_d = mem_write;
          cnt_d   = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            do_op    = 1'b1;
            op_wr    = mem_write;
            op_addr  = addr;
            op_wdata = wdata;
            state_d  = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (mem_read || mem_write) overrun_d = 1'b1;
        if (cnt_q == 4'd1) begin
          do_op   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdata_d = rdata_q;
    if (do_op && !op_wr) rdata_d = mem[op_addr];
  end

  // Control and result registers; rst clears everything but the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_wr_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_wr_q   <= op_wr_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  // Write commit; gated by state so a reset in WAIT drops the pending write.
  always_ff @(posedge clk) begin
    if (do_op && op_wr) mem[op_addr] <= op_wdata;
  end

  assign ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy       = (state_q == S_WAIT);
  assign rdata      = rdata_q;
  assign data_valid = (state_q == S_DONE) && !op_wr_q;
  assign write_done = (state_q == S_DONE) &&  op_wr_q;
  assign req_err    = err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_mem_responder.sv
// Table-driven bench: one instance with two wait states, one with none.
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_rd, a_wr, a_ready, a_busy, a_dv, a_wd, a_err, a_ovr;
  logic [7:0]  a_addr;
  logic [12:0] a_wdata, a_rdata;
  logic        b_rst, b_rd, b_wr, b_ready, b_busy, b_dv, b_wd, b_err, b_ovr;
  logic [7:0]  b_addr;
  logic [12:0] b_wdata, b_rdata;

  mem_responder #(.ADDR_W(8), .DATA_W(13), .WAIT_CYCLES(2), .INIT_FILE("")) u_a (
    .clk(clk), .rst(a_rst), .mem_read(a_rd), .mem_write(a_wr), .addr(a_addr),
    .wdata(a_wdata), .ready(a_ready), .busy(a_busy), .rdata(a_rdata),
    .data_valid(a_dv), .write_done(a_wd), .req_err(a_err), .overrun(a_ovr));

  mem_responder #(.ADDR_W(8), .DATA_W(13), .WAIT_CYCLES(0), .INIT_FILE("")) u_b (
    .clk(clk), .rst(b_rst), .mem_read(b_rd), .mem_write(b_wr), .addr(b_addr),
    .wdata(b_wdata), .ready(b_ready), .busy(b_busy), .rdata(b_rdata),
    .data_valid(b_dv), .write_done(b_wd), .req_err(b_err), .overrun(b_ovr));

  typedef struct {
    logic        rd, wr;
    logic [7:0]  addr;
    logic [12:0] wdata;
    logic        ready, busy, dv, wd, err, ovr;
    logic [12:0] rdata;
  } vec_t;

  int n_run = 0, n_fail = 0;
  vec_t ta[$];
  vec_t tb[$];

  function automatic vec_t mk(logic rd, logic wr, logic [7:0] ad, logic [12:0] wd_i,
                              logic rdy, logic bsy, logic dv, logic wdn, logic er,
                              logic ov, logic [12:0] rdt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = ad; v.wdata = wd_i;
    v.ready = rdy; v.busy = bsy; v.dv = dv; v.wd = wdn; v.err = er; v.ovr = ov;
    v.rdata = rdt;
    return v;
  endfunction

  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy/bsy/dv/wd/err/ovr=%b rdata=%h, want %b rdata=%h",
               name, act[18:13], act[12:0], exp[18:13], exp[12:0]);
    end
  endtask

  // Drive one row's inputs, compare this cycle's outputs, then advance a cycle.
  task automatic run_row(input bit use_b, input int idx, input vec_t v);
    logic [18:0] act, exp;
    exp = {v.ready, v.busy, v.dv, v.wd, v.err, v.ovr, v.rdata};
    if (!use_b) begin
      a_rd = v.rd; a_wr = v.wr; a_addr = v.addr; a_wdata = v.wdata;
      act = {a_ready, a_busy, a_dv, a_wd, a_err, a_ovr, a_rdata};
      check($sformatf("A row %0d", idx), act, exp);
    end else begin
      b_rd = v.rd; b_wr = v.wr; b_addr = v.addr; b_wdata = v.wdata;
      act = {b_ready, b_busy, b_dv, b_wd, b_err, b_ovr, b_rdata};
      check($sformatf("B row %0d", idx), act, exp);
      n_run++;
      if (b_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL B ready row %0d: got %b want 1", idx, b_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Instance A, WAIT_CYCLES=2. Columns: rd wr addr wdata | rdy bsy dv wd err ovr rdata
    ta.push_back(mk(0,1,8'h05,13'h0ABC, 1,0,0,0,0,0,13'h0000)); // preload 0x05
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0000));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0000));
    ta.push_back(mk(0,1,8'h20,13'h0555, 1,0,0,1,0,0,13'h0000)); // accept in DONE
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0000));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0000));
    ta.push_back(mk(1,0,8'h05,13'h0000, 1,0,0,1,0,0,13'h0000)); // read 0x05
    ta.push_back(mk(0,0,8'h77,13'h1111, 0,1,0,0,0,0,13'h0000)); // addr change ignored
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0000));
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,1,0,0,0,13'h0ABC)); // 3 cycles after accept
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,0,0,0,0,13'h0ABC)); // held
    ta.push_back(mk(0,1,8'h10,13'h1234, 1,0,0,0,0,0,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,0,1,0,0,13'h0ABC)); // write doesn't touch rdata
    ta.push_back(mk(1,0,8'h10,13'h0000, 1,0,0,0,0,0,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,1,0,0,0,13'h1234));
    ta.push_back(mk(1,1,8'h20,13'h1FFF, 1,0,0,0,0,0,13'h1234)); // both strobes
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,0,0,1,0,13'h1234)); // req_err pulse
    ta.push_back(mk(1,0,8'h20,13'h0000, 1,0,0,0,0,0,13'h1234));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h1234));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h1234));
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,1,0,0,0,13'h0555)); // 0x20 unchanged
    ta.push_back(mk(1,0,8'h05,13'h0000, 1,0,0,0,0,0,13'h0555));
    ta.push_back(mk(1,0,8'h10,13'h0000, 0,1,0,0,0,0,13'h0555)); // presented in WAIT
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,1,13'h0555));
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,1,0,0,1,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,0,0,0,1,13'h0ABC)); // no second pulse
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,0,0,0,1,13'h0ABC));
    ta.push_back(mk(0,1,8'h30,13'h0111, 1,0,0,0,0,1,13'h0ABC)); // old contents of 0x30
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,1,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 0,1,0,0,0,1,13'h0ABC));
    ta.push_back(mk(0,0,8'h00,13'h0000, 1,0,0,1,0,1,13'h0ABC));

    // Instance B, WAIT_CYCLES=0: access at accept edge, pulse next cycle.
    tb.push_back(mk(0,1,8'h01,13'h0AAA, 1,0,0,0,0,0,13'h0000));
    tb.push_back(mk(0,1,8'h02,13'h0BBB, 1,0,0,1,0,0,13'h0000));
    tb.push_back(mk(1,0,8'h01,13'h0000, 1,0,0,1,0,0,13'h0000));
    tb.push_back(mk(1,0,8'h02,13'h0000, 1,0,1,0,0,0,13'h0AAA));
    tb.push_back(mk(0,0,8'h00,13'h0000, 1,0,1,0,0,0,13'h0BBB));
    tb.push_back(mk(0,0,8'h00,13'h0000, 1,0,0,0,0,0,13'h0BBB));

    a_rst = 1'b1; a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("A reset state", {a_ready, a_busy, a_dv, a_wd, a_err, a_ovr, a_rdata},
          {6'b100000, 13'h0000});
    check("B reset state", {b_ready, b_busy, b_dv, b_wd, b_err, b_ovr, b_rdata},
          {6'b100000, 13'h0000});
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;

    foreach (ta[i]) run_row(1'b0, i, ta[i]);

    // Reset during WAIT of a write: write must not commit, overrun must clear.
    a_rd = 0; a_wr = 1; a_addr = 8'h30; a_wdata = 13'h0FFF;
    @(posedge clk); #1;
    a_wr = 0; a_addr = '0; a_wdata = '0;
    a_rst = 1'b1;
    #1;
    check("A async reset in WAIT", {a_ready, a_busy, a_dv, a_wd, a_err, a_ovr, a_rdata},
          {6'b100000, 13'h0000});
    @(posedge clk); #1;
    a_rst = 1'b0;
    for (int k = 0; k < 3; k++)
      run_row(1'b0, 100 + k, mk(0,0,8'h00,13'h0000, 1,0,0,0,0,0,13'h0000));
    run_row(1'b0, 103, mk(1,0,8'h30,13'h0000, 1,0,0,0,0,0,13'h0000));
    run_row(1'b0, 104, mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0000));
    run_row(1'b0, 105, mk(0,0,8'h00,13'h0000, 0,1,0,0,0,0,13'h0000));
    run_row(1'b0, 106, mk(0,0,8'h00,13'h0000, 1,0,1,0,0,0,13'h0111));

    foreach (tb[i]) run_row(1'b1, i, tb[i]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
